// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the counter-width helper.
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DONE  = 2'd2
  } sa_state_t;

  // The bit counter must index WIDTH steps; never let it collapse to 0 bits.
  function automatic int sa_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell from the arithmetic library.
module FULLADDER (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ C;
  assign carry = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB-first operand shift registers and
// a carry flip-flop sequenced by an IDLE/SHIFT/DONE controller.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int            CW   = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_s_sr;
  logic             r_c_q;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_s_full;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  FULLADDER u_fa (
    .A    (r_a_sr[0]),
    .B    (r_b_sr[0]),
    .C    (r_c_q),
    .sum  (w_s),
    .carry(w_co)
  );

  assign w_load = (r_state == SA_IDLE) && start;
  assign w_step = (r_state == SA_SHIFT);
  assign w_last = w_step && (r_cnt == LAST);

  // The lowest sum bit is shifted out unread, so only the upper WIDTH-1 bits
  // are stored; w_s_full is the complete sum register after this step.
  assign w_s_full = {w_s, r_s_sr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SA_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      SA_IDLE: begin
        if (start) w_next = SA_SHIFT;
      end
      SA_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = SA_DONE;
      end
      SA_DONE: begin
        done   = 1'b1;
        w_next = SA_IDLE;
      end
      default: w_next = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_s_sr <= '0;
      r_c_q  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_a_sr <= A;
      r_b_sr <= B;
      r_c_q  <= C;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_s_sr <= w_s_full[WIDTH-1:1];
      r_c_q  <= w_co;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Result holds until the final bit step of the next add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (w_last) begin
      sum   <= w_s_full;
      carry <= w_co;
    end
  end

endmodule
